// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: 2-flop synchronizer, joint 2-bit persistence filter,
// and a Gray-code step decoder that emits single-cycle up/down/err pulses.
module quad_step_decoder #(
  parameter int unsigned FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic up,
  output logic down,
  output logic err,
  output logic dir,
  output logic dbg_state_o
);

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } state_e;

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] FILT_C = CW'(FILT);

  logic          a_meta_q, a_sync_q;
  logic          b_meta_q, b_sync_q;
  logic [1:0]    prime_q, prime_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    f_q, f_d;
  logic [1:0]    prev_q, prev_d;
  logic          chg_q, chg_d;
  state_e        state_q, state_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          err_q, err_d;
  logic          dir_q, dir_d;

  logic [1:0]    s;
  logic          accept;
  logic [1:0]    step;

  // Position of a Gray code along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign s = {a_sync_q, b_sync_q};

  // prime_q masks the two edges after reset where the synchronizer still holds
  // its reset value, so those samples never count toward a filter value.
  always_comb begin
    prime_d = {prime_q[0], 1'b1};
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (prime_q[1]) begin
      if (s != cand_q) begin
        cand_d = s;
        cnt_d  = CW'(1);
      end else if (cnt_q < FILT_C) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    accept = prime_q[1] && (cnt_d >= FILT_C) &&
             ((state_q == UNPRIMED) || (s != f_q));

    f_d     = f_q;
    prev_d  = prev_q;
    state_d = state_q;
    chg_d   = 1'b0;
    if (accept) begin
      f_d     = s;
      prev_d  = f_q;
      chg_d   = (state_q == TRACK);
      state_d = TRACK;
    end

    // Decode one cycle after f changes so the pulse is fully registered.
    step   = gray_idx(f_q) - gray_idx(prev_q);
    up_d   = chg_q && (step == 2'd1);
    down_d = chg_q && (step == 2'd3);
    err_d  = chg_q && (step == 2'd2);
    dir_d  = dir_q;
    if (up_d) begin
      dir_d = 1'b1;
    end else if (down_d) begin
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      prime_q  <= 2'b00;
      cand_q   <= 2'b00;
      cnt_q    <= '0;
      f_q      <= 2'b00;
      prev_q   <= 2'b00;
      chg_q    <= 1'b0;
      state_q  <= UNPRIMED;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      a_meta_q <= a_in;
      a_sync_q <= a_meta_q;
      b_meta_q <= b_in;
      b_sync_q <= b_meta_q;
      prime_q  <= prime_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      f_q      <= f_d;
      prev_q   <= prev_d;
      chg_q    <= chg_d;
      state_q  <= state_d;
      up_q     <= up_d;
      down_q   <= down_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
    end
  end

  assign up          = up_q;
  assign down        = down_q;
  assign err         = err_q;
  assign dir         = dir_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (FILT=4): step sequences, glitches,
// illegal jumps and reset behaviour, with an ordered pulse scoreboard.
module tb_quad_step_decoder;

  localparam int FILT = 4;
  localparam logic [2:0] P_UP = 3'b100;
  localparam logic [2:0] P_DN = 3'b010;
  localparam logic [2:0] P_ER = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic up, down, err, dir, dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  quad_step_decoder #(.FILT(FILT)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_in        (a_in),
    .b_in        (b_in),
    .up          (up),
    .down        (down),
    .err         (err),
    .dir         (dir),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every pulse seen must be the next expected one, in order.
  always @(negedge clk) begin
    if (up || down || err) begin
      if (exp_q.size() == 0) check("sb.extra", int'({up, down, err}), 0);
      else check("sb.pulse", int'({up, down, err}), int'(exp_q.pop_front()));
    end
  end

  task automatic check_reset(input string tag);
    check({tag, ".up"}, int'(up), 0);
    check({tag, ".down"}, int'(down), 0);
    check({tag, ".err"}, int'(err), 0);
    check({tag, ".dir"}, int'(dir), 0);
    check({tag, ".state"}, int'(dbg_state), 0);
  endtask

  // Drive A/B just after a rising edge, then watch `hold` edges: count pulse
  // cycles, note the edge index of the first one, and check dir at the end.
  task automatic drive_ab(input logic [1:0] ab, input int hold, input int exp_n,
                          input int exp_lat, input logic exp_dir, input string tag);
    int n_hi;
    int pos;
    n_hi = 0;
    pos  = 0;
    a_in = ab[1];
    b_in = ab[0];
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (up || down || err) begin
        n_hi++;
        if (pos == 0) pos = i;
      end
    end
    check({tag, ".n"}, n_hi, exp_n);
    if (exp_lat != 0) check({tag, ".lat"}, pos, exp_lat);
    check({tag, ".dir"}, int'(dir), int'(exp_dir));
  endtask

  initial begin
    #3 rst = 1'b0;
    #1 check_reset("rst0");
    repeat (3) @(posedge clk);
    #1 check_reset("rst1");
    rst = 1'b1;

    drive_ab(2'b00, 10, 0, 0, 1'b0, "prime");
    check("prime.state", int'(dbg_state), 1);

    // Input change lands before edge k; the pulse shows at edge k+6 = index 7.
    exp_q.push_back(P_UP); drive_ab(2'b01, 8, 1, 7, 1'b1, "fwd1");
    exp_q.push_back(P_UP); drive_ab(2'b11, 8, 1, 7, 1'b1, "fwd2");
    exp_q.push_back(P_UP); drive_ab(2'b10, 8, 1, 7, 1'b1, "fwd3");
    exp_q.push_back(P_UP); drive_ab(2'b00, 8, 1, 7, 1'b1, "fwd4");

    exp_q.push_back(P_DN); drive_ab(2'b10, 8, 1, 7, 1'b0, "rev1");
    exp_q.push_back(P_DN); drive_ab(2'b11, 8, 1, 7, 1'b0, "rev2");
    exp_q.push_back(P_DN); drive_ab(2'b01, 8, 1, 7, 1'b0, "rev3");
    exp_q.push_back(P_DN); drive_ab(2'b00, 8, 1, 7, 1'b0, "rev4");
    exp_q.push_back(P_UP); drive_ab(2'b01, 8, 1, 7, 1'b1, "rev5");
    exp_q.push_back(P_DN); drive_ab(2'b00, 8, 1, 7, 1'b0, "home");

    // Short pulse on b (00->01) is dropped; a 4-cycle one steps up then down.
    drive_ab(2'b01, 3, 0, 0, 1'b0, "gb3");
    drive_ab(2'b00, 10, 0, 0, 1'b0, "gb3r");
    exp_q.push_back(P_UP); exp_q.push_back(P_DN);
    drive_ab(2'b01, 4, 0, 0, 1'b0, "gb4");
    drive_ab(2'b00, 12, 2, 3, 1'b0, "gb4r");

    // Same on a: 00->10 is the reverse direction, so down first, then up.
    drive_ab(2'b10, 3, 0, 0, 1'b0, "ga3");
    drive_ab(2'b00, 10, 0, 0, 1'b0, "ga3r");
    exp_q.push_back(P_DN); exp_q.push_back(P_UP);
    drive_ab(2'b10, 4, 0, 0, 1'b0, "ga4");
    drive_ab(2'b00, 12, 2, 3, 1'b1, "ga4r");

    exp_q.push_back(P_ER); drive_ab(2'b11, 8, 1, 7, 1'b1, "ill");
    exp_q.push_back(P_UP); drive_ab(2'b10, 8, 1, 7, 1'b1, "ill_next");

    // Baseline 11 held through reset release loads silently at edge FILT+2.
    rst  = 1'b0;
    a_in = 1'b1;
    b_in = 1'b1;
    #1 check_reset("rstb");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 1; i <= FILT + 2; i++) begin
      @(posedge clk);
      #1;
      if (i == FILT + 1) check("base.pre", int'(dbg_state), 0);
      if (i == FILT + 2) check("base.load", int'(dbg_state), 1);
    end
    drive_ab(2'b11, 6, 0, 0, 1'b0, "base_hold");
    exp_q.push_back(P_UP); drive_ab(2'b10, 8, 1, 7, 1'b1, "base_step");

    // Reset two cycles into filtering 00->01 must swallow that step.
    exp_q.push_back(P_UP); drive_ab(2'b00, 8, 1, 7, 1'b1, "mf_home");
    a_in = 1'b0;
    b_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset("mf_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mf.rel_state", int'(dbg_state), 0);
    drive_ab(2'b01, 12, 0, 0, 1'b0, "mf_after");
    check("mf.state", int'(dbg_state), 1);

    check("sb.drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
